// File: rtl/rr_arb_mux.sv
// Registered N:1 round-robin arbitrating multiplexer with valid/ready on every port.
// Define RR_MUX_FIXED_PRIO_EN to make the lowest-index valid channel always win.
module rr_arb_mux #(
   parameter int WIDTH = 32,
   parameter int NCH   = 4,
   localparam int CW   = (NCH > 1) ? $clog2(NCH) : 1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [NCH*WIDTH-1:0] in_data,
   input  logic [NCH-1:0]       in_valid,
   output logic [NCH-1:0]       in_ready,
   output logic [WIDTH-1:0]     out_data,
   output logic [CW-1:0]        out_chan,
   output logic                 out_valid,
   input  logic                 out_ready
);

   typedef enum logic {EMPTY, FULL} state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic [CW-1:0]    chan_q, chan_d;
   logic [CW-1:0]    ptr_q, ptr_d;

   logic             load;
   logic             accept;
   logic             grant_vld;
   logic             hi_vld;
   logic [CW-1:0]    hi_idx;
   logic [CW-1:0]    lo_idx;
   logic [CW-1:0]    grant_idx;

   // Round-robin search split in two: lowest valid at or above ptr, else lowest valid overall.
   always_comb begin
      hi_vld    = 1'b0;
      hi_idx    = '0;
      lo_idx    = '0;
      grant_vld = |in_valid;
      for (int i = NCH - 1; i >= 0; i--) begin
         if (in_valid[i]) begin
            lo_idx = CW'(i);
            if (i >= int'(ptr_q)) begin
               hi_vld = 1'b1;
               hi_idx = CW'(i);
            end
         end
      end
      grant_idx = hi_vld ? hi_idx : lo_idx;
   end

   assign load   = (state_q == EMPTY) | out_ready;
   assign accept = load & grant_vld & ~reset;

   always_comb begin
      in_ready = '0;
      for (int i = 0; i < NCH; i++) begin
         in_ready[i] = accept && (grant_idx == CW'(i));
      end
   end

   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      chan_d  = chan_q;
      ptr_d   = ptr_q;
      if (accept) begin
         state_d = FULL;
         data_d  = in_data[int'(grant_idx)*WIDTH +: WIDTH];
         chan_d  = grant_idx;
`ifdef RR_MUX_FIXED_PRIO_EN
         ptr_d   = '0;
`else
         ptr_d   = (grant_idx == CW'(NCH - 1)) ? '0 : grant_idx + CW'(1);
`endif
      end else if (out_ready) begin
         state_d = EMPTY;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= EMPTY;
         data_q  <= '0;
         chan_q  <= '0;
         ptr_q   <= '0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         chan_q  <= chan_d;
         ptr_q   <= ptr_d;
      end
   end

   assign out_valid = (state_q == FULL);
   assign out_data  = data_q;
   assign out_chan  = chan_q;

endmodule

// File: tb/tb_rr_arb_mux.sv
// Self-checking bench for rr_arb_mux (WIDTH=32, NCH=4) against a queue-free behavioural model.
// Honours RR_MUX_FIXED_PRIO_EN the same way the design does.
module tb_rr_arb_mux;

   localparam int WIDTH = 32;
   localparam int NCH   = 4;

   logic                 clk;
   logic                 reset;
   logic [NCH*WIDTH-1:0] in_data;
   logic [NCH-1:0]       in_valid;
   logic [NCH-1:0]       in_ready;
   logic [WIDTH-1:0]     out_data;
   logic [1:0]           out_chan;
   logic                 out_valid;
   logic                 out_ready;

   rr_arb_mux #(.WIDTH(WIDTH), .NCH(NCH)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_data  (out_data),
      .out_chan  (out_chan),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: a one-entry output buffer plus a "next channel to favour" pointer.
   logic             m_valid;
   logic [WIDTH-1:0] m_data;
   logic [1:0]       m_chan;
   int               m_ptr;
   logic [NCH-1:0]   exp_ready;
   logic [NCH-1:0]   seen_ready;

   function automatic logic [WIDTH-1:0] chan_word(input int c);
      return 32'hffff0000 | ((c + 1) * 32'h1111);
   endfunction

   function automatic int model_grant(input logic [NCH-1:0] v, input int p);
      for (int k = 0; k < NCH; k++) begin
         if (v[(p + k) % NCH]) return (p + k) % NCH;
      end
      return -1;
   endfunction

   task automatic cycle(input logic rst, input logic [NCH-1:0] v, input logic ordy,
                        input logic rnd);
      logic [WIDTH-1:0] words [NCH];
      int g;
      logic ld;
      @(negedge clk);
      reset     = rst;
      in_valid  = v;
      out_ready = ordy;
      for (int c = 0; c < NCH; c++) begin
         words[c] = rnd ? WIDTH'($urandom) : chan_word(c);
         in_data[c*WIDTH +: WIDTH] = words[c];
      end
      #1;
      seen_ready = in_ready;
      g  = model_grant(v, m_ptr);
      ld = !m_valid || ordy;
      exp_ready = '0;
      if (!rst && ld && g >= 0) exp_ready[g] = 1'b1;
      if (rst) begin
         m_valid = 1'b0;
         m_data  = '0;
         m_chan  = '0;
         m_ptr   = 0;
      end else if (ld && g >= 0) begin
         m_valid = 1'b1;
         m_data  = words[g];
         m_chan  = 2'(g);
`ifdef RR_MUX_FIXED_PRIO_EN
         m_ptr   = 0;
`else
         m_ptr   = (g + 1) % NCH;
`endif
      end else if (ordy) begin
         m_valid = 1'b0;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      for (int n = 0; n < 2; n++) begin
         cycle(1'b1, 4'b1111, 1'b1, 1'b0);
         n_checks++;
         if (seen_ready !== 4'b0000) begin
            n_fail++;
            $display("[TB] FAIL reset_in_ready: got %b want 0000", seen_ready);
         end
         n_checks++;
         if (out_valid !== 1'b0 || out_data !== 32'h0 || out_chan !== 2'd0) begin
            n_fail++;
            $display("[TB] FAIL reset_outputs: got v=%b d=%h c=%0d want 0/0/0",
                     out_valid, out_data, out_chan);
         end
      end
   endtask

   task automatic test_round_robin();
`ifdef RR_MUX_FIXED_PRIO_EN
      logic [1:0] seq [6] = '{0, 0, 0, 0, 0, 0};
`else
      logic [1:0] seq [6] = '{0, 1, 2, 3, 0, 1};
`endif
      for (int n = 0; n < 6; n++) begin
         cycle(1'b0, 4'b1111, 1'b1, 1'b0);
         n_checks++;
         if (seen_ready !== exp_ready) begin
            n_fail++;
            $display("[TB] FAIL rr_in_ready[%0d]: got %b want %b", n, seen_ready, exp_ready);
         end
         n_checks++;
         if (out_valid !== 1'b1 || out_chan !== seq[n] || out_data !== chan_word(int'(seq[n]))) begin
            n_fail++;
            $display("[TB] FAIL rr_seq[%0d]: got v=%b c=%0d d=%h want 1/%0d/%h",
                     n, out_valid, out_chan, out_data, seq[n], chan_word(int'(seq[n])));
         end
      end
   endtask

   task automatic test_single_channel();
      cycle(1'b0, 4'b0100, 1'b1, 1'b0);
      n_checks++;
      if (seen_ready !== 4'b0100) begin
         n_fail++;
         $display("[TB] FAIL single_in_ready: got %b want 0100", seen_ready);
      end
      n_checks++;
      if (out_valid !== 1'b1 || out_data !== 32'hffff3333 || out_chan !== 2'd2) begin
         n_fail++;
         $display("[TB] FAIL single_out: got v=%b d=%h c=%0d want 1/ffff3333/2",
                  out_valid, out_data, out_chan);
      end
`ifndef RR_MUX_FIXED_PRIO_EN
      cycle(1'b0, 4'b1001, 1'b1, 1'b0);
      n_checks++;
      if (out_chan !== 2'd3 || out_data !== 32'hffff4444) begin
         n_fail++;
         $display("[TB] FAIL pair_first: got c=%0d d=%h want 3/ffff4444", out_chan, out_data);
      end
      cycle(1'b0, 4'b1001, 1'b1, 1'b0);
      n_checks++;
      if (out_chan !== 2'd0 || out_data !== 32'hffff1111) begin
         n_fail++;
         $display("[TB] FAIL pair_second: got c=%0d d=%h want 0/ffff1111", out_chan, out_data);
      end
`endif
      cycle(1'b0, 4'b0000, 1'b1, 1'b0);
      n_checks++;
      if (out_valid !== 1'b0 || seen_ready !== 4'b0000) begin
         n_fail++;
         $display("[TB] FAIL idle_drain: got v=%b rdy=%b want 0/0000", out_valid, seen_ready);
      end
   endtask

   task automatic test_stall();
      logic [WIDTH-1:0] held_data;
      logic [1:0]       held_chan;
      cycle(1'b0, 4'b1111, 1'b1, 1'b0);
      held_data = m_data;
      held_chan = m_chan;
      for (int n = 0; n < 5; n++) begin
         cycle(1'b0, 4'b1111, 1'b0, 1'b0);
         n_checks++;
         if (seen_ready !== 4'b0000) begin
            n_fail++;
            $display("[TB] FAIL stall_in_ready[%0d]: got %b want 0000", n, seen_ready);
         end
         n_checks++;
         if (out_valid !== 1'b1 || out_data !== held_data || out_chan !== held_chan) begin
            n_fail++;
            $display("[TB] FAIL stall_hold[%0d]: got v=%b d=%h c=%0d want 1/%h/%0d",
                     n, out_valid, out_data, out_chan, held_data, held_chan);
         end
      end
      cycle(1'b0, 4'b1111, 1'b1, 1'b0);
      n_checks++;
      if (seen_ready !== exp_ready || seen_ready === 4'b0000) begin
         n_fail++;
         $display("[TB] FAIL release_in_ready: got %b want %b", seen_ready, exp_ready);
      end
      n_checks++;
      if (out_valid !== 1'b1 || out_chan !== m_chan || out_data !== m_data) begin
         n_fail++;
         $display("[TB] FAIL release_next: got v=%b c=%0d d=%h want 1/%0d/%h",
                  out_valid, out_chan, out_data, m_chan, m_data);
      end
   endtask

   task automatic test_reset_mid();
      cycle(1'b0, 4'b1111, 1'b0, 1'b0);
      cycle(1'b1, 4'b1111, 1'b0, 1'b0);
      n_checks++;
      if (out_valid !== 1'b0 || out_data !== 32'h0 || seen_ready !== 4'b0000) begin
         n_fail++;
         $display("[TB] FAIL midreset: got v=%b d=%h rdy=%b want 0/0/0000",
                  out_valid, out_data, seen_ready);
      end
      cycle(1'b0, 4'b1111, 1'b1, 1'b0);
      n_checks++;
      if (out_valid !== 1'b1 || out_chan !== 2'd0 || out_data !== 32'hffff1111) begin
         n_fail++;
         $display("[TB] FAIL midreset_regrant: got v=%b c=%0d d=%h want 1/0/ffff1111",
                  out_valid, out_chan, out_data);
      end
   endtask

   task automatic test_fixed_priority();
`ifdef RR_MUX_FIXED_PRIO_EN
      for (int n = 0; n < 4; n++) begin
         cycle(1'b0, 4'b1111, 1'b1, 1'b0);
         n_checks++;
         if (out_chan !== 2'd0) begin
            n_fail++;
            $display("[TB] FAIL fixed_ch0[%0d]: got c=%0d want 0", n, out_chan);
         end
      end
      cycle(1'b0, 4'b1110, 1'b1, 1'b0);
      n_checks++;
      if (out_chan !== 2'd1 || out_data !== 32'hffff2222) begin
         n_fail++;
         $display("[TB] FAIL fixed_ch1: got c=%0d d=%h want 1/ffff2222", out_chan, out_data);
      end
`endif
   endtask

   task automatic test_random();
      for (int n = 0; n < 400; n++) begin
         cycle(($urandom_range(0, 49) == 0), NCH'($urandom), ($urandom_range(0, 3) != 0), 1'b1);
         n_checks++;
         if (seen_ready !== exp_ready) begin
            n_fail++;
            $display("[TB] FAIL rand_in_ready[%0d]: got %b want %b", n, seen_ready, exp_ready);
         end
         n_checks++;
         if (out_valid !== m_valid || (m_valid && (out_data !== m_data || out_chan !== m_chan))) begin
            n_fail++;
            $display("[TB] FAIL rand_out[%0d]: got v=%b d=%h c=%0d want %b/%h/%0d",
                     n, out_valid, out_data, out_chan, m_valid, m_data, m_chan);
         end
      end
   endtask

   initial begin
      reset     = 1'b1;
      in_valid  = '0;
      in_data   = '0;
      out_ready = 1'b0;
      m_valid   = 1'b0;
      m_data    = '0;
      m_chan    = '0;
      m_ptr     = 0;
      test_reset();
      test_round_robin();
      test_single_channel();
      test_stall();
      test_reset_mid();
      test_fixed_priority();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
